// File: rtl/spi_tx_arbiter.sv
// Round-robin scheduler for two message producers sharing one SPI-slave send path.
// Optional watchdog abort is built when SPI_ARB_WATCHDOG_EN is defined.
module spi_tx_arbiter #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000,
  parameter int          DATA_W         = 48
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req0,
  input  logic [DATA_W-1:0] msg0_data,
  input  logic [2:0]        msg0_type,
  output logic              ack0,
  input  logic              req1,
  input  logic [DATA_W-1:0] msg1_data,
  input  logic [2:0]        msg1_type,
  output logic              ack1,
  output logic              spi_send_trigger,
  output logic [DATA_W-1:0] spi_output_data,
  output logic [2:0]        spi_msg_type,
  input  logic              spi_busy,
  output logic              spi_irq,
  output logic              grant_id,
  output logic              spi_abort,
  output logic              err_timeout
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, DONE} state_t;

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              grant_q, grant_d;
  logic              trig_q, trig_d;
  logic              irq_q, irq_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [2:0]        type_q, type_d;
  logic              pick;
  logic              timeout;

`ifdef SPI_ARB_WATCHDOG_EN
  logic [15:0] wdog_q;
  logic        tmo_q;

  assign timeout = ((state_q == ISSUE) || (state_q == WAIT_DONE)) &&
                   (wdog_q == (TIMEOUT_CYCLES - 16'd1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      wdog_q <= 16'd0;
      tmo_q  <= 1'b0;
    end else begin
      tmo_q <= timeout;
      if ((state_q == IDLE) && (state_d == ISSUE))
        wdog_q <= 16'd0;
      else if ((state_q == ISSUE) || (state_q == WAIT_DONE))
        wdog_q <= wdog_q + 16'd1;
    end
  end

  assign spi_abort   = tmo_q;
  assign err_timeout = tmo_q;
`else
  logic unused_tmo;

  assign unused_tmo  = ^TIMEOUT_CYCLES;
  assign timeout     = 1'b0;
  assign spi_abort   = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    trig_d       = trig_q;
    irq_d        = irq_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    data_d       = data_q;
    type_d       = type_q;
    pick         = 1'b0;
    if (timeout) begin
      trig_d  = 1'b0;
      irq_d   = 1'b0;
      state_d = DONE;
    end else begin
      case (state_q)
        IDLE: begin
          // The cycle carrying an ack still sees the old req high, so it never arbitrates.
          if (!spi_busy && !ack0_q && !ack1_q && (req0 || req1)) begin
            pick         = (req0 && req1) ? ~last_grant_q : req1;
            grant_d      = pick;
            last_grant_d = pick;
            data_d       = pick ? msg1_data : msg0_data;
            type_d       = pick ? msg1_type : msg0_type;
            trig_d       = 1'b1;
            irq_d        = 1'b1;
            state_d      = ISSUE;
          end
        end
        ISSUE: begin
          if (spi_busy) begin
            trig_d  = 1'b0;
            state_d = WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (!spi_busy) begin
            irq_d   = 1'b0;
            state_d = DONE;
          end
        end
        DONE: begin
          ack0_d  = ~grant_q;
          ack1_d  = grant_q;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      trig_q       <= 1'b0;
      irq_q        <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      data_q       <= '0;
      type_q       <= 3'b000;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      trig_q       <= trig_d;
      irq_q        <= irq_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      data_q       <= data_d;
      type_q       <= type_d;
    end
  end

  assign ack0             = ack0_q;
  assign ack1             = ack1_q;
  assign spi_send_trigger = trig_q;
  assign spi_output_data  = data_q;
  assign spi_msg_type     = type_q;
  assign spi_irq          = irq_q;
  assign grant_id         = grant_q;

endmodule

// File: doc/spi_tx_arbiter.md
Name: spi_tx_arbiter

Overview:
Schedules outbound SPI-slave transmissions from two independent requesters onto the single SPInew send path. Round-robin arbitration; drives send_trigger, output_data and SPI_MSG_TYPE, and tracks busy through completion. Raises an attention line so the SPI master knows to clock out a pending message. Sits between the message producers (status logic, data capture) and the SPI slave core.

Parameters:
TIMEOUT_CYCLES, 16'd50000, watchdog limit in CLK cycles for one transaction (used only with the optional feature).

Ports:
CLK  in  1  system clock; all logic on the rising edge
RST  in  1  synchronous reset, active-high
req0  in  1  requester 0 wants to send; held high until ack0
msg0_data  in  48  requester 0 payload, MSB-first per SPI core
msg0_type  in  3  requester 0 message type code (001/010/011/110/111)
ack0  out  1  one-cycle pulse: requester 0 message fully shifted out
req1, msg1_data, msg1_type, ack1  as requester 0, for requester 1
spi_send_trigger  out  1  to SPI core send_trigger
spi_output_data  out  48  to SPI core output_data
spi_msg_type  out  3  to SPI core SPI_MSG_TYPE
spi_busy  in  1  from SPI core busy
spi_irq  out  1  attention to SPI master: message pending/in progress
grant_id  out  1  requester currently granted (valid while spi_irq=1)
spi_abort  out  1  one-cycle reset pulse to SPI core (feature only)
err_timeout  out  1  one-cycle pulse on watchdog abort (feature only)

Behaviour:
- Reset (synchronous, RST=1 at a rising edge): state=IDLE; ack0/ack1=0; spi_send_trigger=0; spi_output_data=48'h0; spi_msg_type=3'b000; spi_irq=0; grant_id=0; spi_abort=0; err_timeout=0; last_grant=1 (so req0 wins the first tie); watchdog=0. Reset mid-transaction drops everything immediately, no ack issued.
- All outputs registered.
- States: IDLE, ISSUE, WAIT_DONE, DONE.
- IDLE: if spi_busy=1 (core is receiving), stay; no grant. Otherwise, if one req is high, grant it; if both, grant the one != last_grant. On grant: latch msgN_data/msgN_type into spi_output_data/spi_msg_type, set grant_id, set last_grant, assert spi_send_trigger and spi_irq, go to ISSUE. Payload is latched once; requester data changes after grant are ignored.
- ISSUE: hold spi_send_trigger=1 until spi_busy=1 is sampled. Then deassert spi_send_trigger and go to WAIT_DONE.
- WAIT_DONE: stay while spi_busy=1. On spi_busy=0: clear spi_irq and go to DONE.
- DONE: pulse ackN (N=grant_id) for exactly one cycle, then go to IDLE. The requester must drop reqN on the edge where ackN is high. A req still high in the following IDLE cycle is treated as a new message.
- Latency: req sampled high in IDLE with spi_busy=0 -> spi_send_trigger high on the next cycle. spi_busy falling -> ack two cycles later.
- A req deasserted before ack is ignored once granted; the transaction completes regardless.
- spi_msg_type is passed through unchecked. Type 000 is forwarded; the core then treats it as a 2-byte message.
- No queueing beyond the two req lines; at most one transaction in flight.

Optional Feature:
SPI_ARB_WATCHDOG_EN
- Defined: a 16-bit watchdog clears on entering ISSUE and increments every cycle in ISSUE/WAIT_DONE.
- On reaching TIMEOUT_CYCLES-1, the next cycle:
  - pulse spi_abort and err_timeout for one cycle;
  - drop spi_send_trigger and spi_irq;
  - pulse ackN (DONE path), then return to IDLE;
  - do not toggle last_grant further.
- Not defined: no counter is built; spi_abort and err_timeout are tied to 0, and the arbiter waits indefinitely in ISSUE/WAIT_DONE.

Test Plan:
- Single request: req0=1, msg0_data=48'h0000_0000_A55A, msg0_type=010. Model busy high for 16 SCK bits -> trigger 1 cycle after req; spi_output_data=48'hA55A; spi_irq high until busy falls; one ack0 pulse; grant_id=0.
- Simultaneous: req0=req1=1 from reset -> grant order 0,1,0,1 over four back-to-back messages; each ack is exactly one cycle wide.
- Receive in progress: spi_busy=1 before req1 rises -> no trigger while busy=1; trigger appears 1 cycle after busy drops.
- Data hold: change msg1_data from 48'h1 to 48'h2 one cycle after grant -> spi_output_data stays 48'h1 through ack1.
- Reset mid-send: assert RST during WAIT_DONE -> next cycle all outputs at reset values, no ack; req still high is then regranted.
- With SPI_ARB_WATCHDOG_EN, TIMEOUT_CYCLES=16, busy stuck at 1 -> after 16 cycles: spi_abort and err_timeout pulse once, ack pulses, state returns to IDLE.
